// File: rtl/decode_pkg.sv
// Shared decode definitions for the issue front end: opcodes, target units,
// immediate formats and the issue FSM states.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_LSU = 2'd1,
    UNIT_BR  = 2'd2
  } unit_e;

  localparam logic [1:0] IMM_NONE = 2'd0;
  localparam logic [1:0] IMM_I    = 2'd1;
  localparam logic [1:0] IMM_S    = 2'd2;
  localparam logic [1:0] IMM_B    = 2'd3;

  typedef enum logic {
    RUN      = 1'b0,
    SER_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/issue_decoder.sv
// Field extraction and immediate generation for one RV32 instruction word.
module issue_decoder
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic [1:0]  imm_type
);

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // U and J immediates are still produced but reported as IMM_NONE
  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
        imm      = {{20{instr[31]}}, instr[31:20]};
        imm_type = IMM_I;
      end
      OP_STORE: begin
        imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_type = IMM_S;
      end
      OP_BRANCH: begin
        imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_type = IMM_B;
      end
      OP_LUI, OP_AUIPC: imm = {instr[31:12], 12'b0};
      OP_JAL: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: begin
        imm      = '0;
        imm_type = IMM_NONE;
      end
    endcase
  end

endmodule

// File: rtl/issue_fifo.sv
// Count-based instruction FIFO holding {pc, instr}; head reads as zero when empty.
module issue_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_instr,
  output logic [31:0] rd_pc,
  output logic [31:0] rd_instr,
  output logic        empty,
  output logic        full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_en;
  logic             pop_en;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign push_en = push && !full && !clear;
  assign pop_en  = pop && !empty && !clear;

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= {wr_pc, wr_instr};
  end

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Zeroing the head while empty keeps the decoded issue fields at 0 after reset
  assign rd_pc    = empty ? '0 : mem[rd_ptr][63:32];
  assign rd_instr = empty ? '0 : mem[rd_ptr][31:0];

endmodule

// File: rtl/issue_ctrl.sv
// Tomasulo issue front end: buffers fetched instructions, classifies the head
// by target unit and issues one per cycle, serialising FENCE/SYSTEM.
module issue_ctrl
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      fetch_instr,
  input  logic [31:0]      fetch_pc,
  input  logic             flush,
  input  logic             rob_full,
  input  logic             rob_empty,
  input  logic             alu_rs_ready,
  input  logic             lsu_rs_ready,
  input  logic             br_rs_ready,
  output logic             issue_valid,
  output logic [1:0]       issue_unit,
  output logic [31:0]      issue_pc,
  output logic [6:0]       issue_opcode,
  output logic [4:0]       issue_rd,
  output logic [4:0]       issue_rs1,
  output logic [4:0]       issue_rs2,
  output logic [2:0]       issue_funct3,
  output logic [6:0]       issue_funct7,
  output logic [31:0]      issue_imm,
  output logic [1:0]       issue_imm_type,
  output logic             illegal_pulse,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e      state;
  state_e      state_next;
  logic [31:0] head_instr;
  logic        empty;
  logic        full;
  logic        pop;
  unit_e       head_unit;
  logic        head_legal;
  logic        head_ser;
  logic        unit_ready;
  logic        ser_go;

  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (fetch_valid),
    .pop      (pop),
    .wr_pc    (fetch_pc),
    .wr_instr (fetch_instr),
    .rd_pc    (issue_pc),
    .rd_instr (head_instr),
    .empty    (empty),
    .full     (full)
  );

  issue_decoder u_dec (
    .instr    (head_instr),
    .opcode   (issue_opcode),
    .rd       (issue_rd),
    .rs1      (issue_rs1),
    .rs2      (issue_rs2),
    .funct3   (issue_funct3),
    .funct7   (issue_funct7),
    .imm      (issue_imm),
    .imm_type (issue_imm_type)
  );

  assign fetch_ready = !full;
  assign issue_unit  = head_unit;
  assign pop         = issue_valid || illegal_pulse;

  always_comb begin
    head_unit  = UNIT_ALU;
    head_legal = 1'b0;
    head_ser   = 1'b0;
    case (issue_opcode)
      OP_REG, OP_IMM, OP_LUI, OP_AUIPC: head_legal = 1'b1;
      OP_FENCE, OP_SYSTEM: begin
        head_legal = 1'b1;
        head_ser   = 1'b1;
      end
      OP_LOAD, OP_STORE: begin
        head_unit  = UNIT_LSU;
        head_legal = 1'b1;
      end
      OP_BRANCH, OP_JAL, OP_JALR: begin
        head_unit  = UNIT_BR;
        head_legal = 1'b1;
      end
      default: head_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (head_unit)
      UNIT_LSU: unit_ready = lsu_rs_ready;
      UNIT_BR:  unit_ready = br_rs_ready;
      default:  unit_ready = alu_rs_ready;
    endcase
  end

  // A serialising head may only leave once everything older has committed
  assign ser_go = rob_empty && !rob_full && alu_rs_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN:      if (!empty && head_ser) state_next = SER_WAIT;
        SER_WAIT: if (!empty && ser_go)   state_next = RUN;
        default:  state_next = RUN;
      endcase
    end
  end

  always_comb begin
    issue_valid   = 1'b0;
    illegal_pulse = 1'b0;
    if (!flush && !empty) begin
      case (state)
        RUN: begin
          if (!head_legal)                            illegal_pulse = 1'b1;
          else if (!head_ser && !rob_full && unit_ready) issue_valid = 1'b1;
        end
        SER_WAIT: issue_valid = ser_go;
        default:  issue_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!empty && !issue_valid && !illegal_pulse && !flush && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
